// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with a start/done handshake and shifts/rotates that move one bit per clock.
// Optional macro ALU_SEQ_FLAGS_EN builds the ovfl/zero flag logic; without it both flags are tied to 0.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] Y,
  output logic             done,
  output logic             busy,
  output logic             ovfl,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1'b1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r, sh_r, sh_next_s, res_s;
  logic [2:0]       mode_r;
  logic [SHW-1:0]   cnt_r;
  logic             capture_s, load_s;

  function automatic logic is_shift(input logic [2:0] m);
    case (m)
      3'b010, 3'b100, 3'b101: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [2:0] m, input logic [WIDTH-1:0] v);
    case (m)
      3'b010:  shift_one = {v[0], v[WIDTH-1:1]};
      3'b100:  shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b101:  shift_one = {v[WIDTH-2:0], v[WIDTH-1]};
      default: shift_one = v;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] exec_res(input logic [2:0] m, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (m)
      3'b000:  exec_res = a - b;
      3'b001:  exec_res = a + {1'b0, a[WIDTH-1:1]};
      3'b011:  exec_res = a + b;
      default: exec_res = a;  // pass, and shift/rotate by zero
    endcase
  endfunction

`ifdef ALU_SEQ_FLAGS_EN
  function automatic logic exec_ovf(input logic [2:0] m, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   c;
    r = exec_res(m, a, b);
    c = {1'b0, a} + {2'b00, a[WIDTH-1:1]};
    case (m)
      3'b000:  exec_ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (r[WIDTH-1] ^ a[WIDTH-1]);
      3'b001:  exec_ovf = c[WIDTH];
      3'b011:  exec_ovf = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (r[WIDTH-1] ^ a[WIDTH-1]);
      default: exec_ovf = 1'b0;
    endcase
  endfunction
`endif

  // Next-state decode; a new op may also be captured on the edge that leaves DONE.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    load_s    = 1'b0;
    res_s     = exec_res(mode_r, a_r, b_r);
    sh_next_s = shift_one(mode_r, sh_r);
    case (state_r)
      IDLE, DONE: begin
        if (strt) begin
          capture_s = 1'b1;
          if (is_shift(mode) && (B[SHW-1:0] != {SHW{1'b0}})) begin
            state_s = SHIFT;
          end else begin
            state_s = EXEC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        load_s  = 1'b1;
        state_s = DONE;
      end
      SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          load_s  = 1'b1;
          res_s   = sh_next_s;
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, operand capture and the bit-serial shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      mode_r  <= 3'b000;
      sh_r    <= {WIDTH{1'b0}};
      cnt_r   <= {SHW{1'b0}};
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        a_r    <= A;
        b_r    <= B;
        mode_r <= mode;
        sh_r   <= A;
        cnt_r  <= B[SHW-1:0];
      end else if (state_r == SHIFT) begin
        sh_r  <= sh_next_s;
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Registered result and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y    <= {WIDTH{1'b0}};
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= load_s;
      if (load_s) begin
        Y <= res_s;
      end
      if (capture_s) begin
        busy <= 1'b1;
      end else if (load_s) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Flags are loaded together with Y; shifts and rotates never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl <= 1'b0;
      zero <= 1'b0;
    end else if (load_s) begin
      ovfl <= (state_r == EXEC) ? exec_ovf(mode_r, a_r, b_r) : 1'b0;
      zero <= (res_s == {WIDTH{1'b0}});
    end
  end
`else
  assign ovfl = 1'b0;
  assign zero = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases, random ops against an arithmetic model,
// handshake, back-to-back throughput and mid-operation reset.
module tb_alu_seq;
  logic       clk, rst_n, strt;
  logic [7:0] A, B, Y;
  logic [2:0] mode;
  logic       done, busy, ovfl, zero;
  int checks = 0;
  int failures = 0;

`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .strt(strt), .A(A), .B(B), .mode(mode),
    .Y(Y), .done(done), .busy(busy), .ovfl(ovfl), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_sh(input logic [2:0] m);
    return (m == 3'd2) || (m == 3'd4) || (m == 3'd5);
  endfunction

  function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    int n;
    logic [15:0] d;
    logic signed [7:0] s;
    n = int'(b[2:0]);
    d = {a, a};
    s = a;
    case (m)
      3'd0:    return a - b;
      3'd1:    return 8'(int'(a) + int'(a) / 2);
      3'd2:    begin d = d >> n; return d[7:0]; end
      3'd3:    return a + b;
      3'd4:    return s >>> n;
      3'd5:    begin d = d << n; return d[15:8]; end
      default: return a;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    case (m)
      3'd0:    begin r = sa - sb; return (r > 127) || (r < -128); end
      3'd1:    return (int'(a) + int'(a) / 2) > 255;
      3'd3:    begin r = sa + sb; return (r > 127) || (r < -128); end
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m, input string tag);
    int lat, bcnt, l;
    logic [7:0] ey;
    ey = ref_y(a, b, m);
    l  = (is_sh(m) && b[2:0] != 3'd0) ? int'(b[2:0]) : 1;
    @(negedge clk);
    A = a; B = b; mode = m; strt = 1'b1;
    @(negedge clk);
    strt = 1'b0; A = 8'($urandom); B = 8'($urandom); mode = 3'($urandom);
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(l + 1));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(l));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'(0));
    chk({tag, "_y"}, 32'(Y), 32'(ey));
    chk({tag, "_ovfl"}, 32'(ovfl), 32'(FLAGS & ref_ovf(a, b, m)));
    chk({tag, "_zero"}, 32'(zero), 32'(FLAGS & (ey == 8'h00)));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk({tag, "_y_hold"}, 32'(Y), 32'(ey));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
  endtask

  initial begin
    logic [7:0] aa[4];
    logic [7:0] bb[4];
    logic [7:0] yv;
    int n, pulses, first;
    aa = '{8'h10, 8'h7F, 8'h80, 8'hF0};
    bb = '{8'h20, 8'h01, 8'h80, 8'h10};
    rst_n = 1'b0; strt = 1'b0; A = 8'h00; B = 8'h00; mode = 3'd0;
    @(negedge clk);
    chk("rst_y", 32'(Y), 32'(0));
    chk("rst_flags", 32'({done, busy, ovfl, zero}), 32'(0));
    rst_n = 1'b1;

    run_op(8'h05, 8'h07, 3'd0, "sub_fe");
    run_op(8'h80, 8'h01, 3'd0, "sub_ovf");
    run_op(8'h64, 8'h00, 3'd1, "x15_64");
    run_op(8'hC8, 8'h00, 3'd1, "x15_c8");
    run_op(8'h00, 8'h00, 3'd1, "x15_zero");
    run_op(8'h81, 8'h03, 3'd2, "ror3");
    run_op(8'h90, 8'h02, 3'd4, "asr2");
    run_op(8'h81, 8'h00, 3'd5, "rol0");
    run_op(8'h81, 8'h07, 3'd5, "rol7");
    run_op(8'h3C, 8'h11, 3'd6, "pass6");
    run_op(8'hA7, 8'h22, 3'd7, "pass7");
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), "rand");
    end

    // Extra strt mid-ROR and operand changes after capture.
    @(negedge clk);
    A = 8'h81; B = 8'h03; mode = 3'd2; strt = 1'b1;
    @(negedge clk);
    strt = 1'b0; A = 8'hFF; B = 8'h05; mode = 3'd3;
    @(negedge clk);
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    pulses = 0; first = 0; yv = 8'h00;
    for (int i = 4; i <= 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        first = i;
        yv = Y;
      end
    end
    chk("hs_pulses", 32'(pulses), 32'(1));
    chk("hs_when", 32'(first), 32'(4));
    chk("hs_y", 32'(yv), 32'(8'h30));

    // Back-to-back ADDs with strt held high.
    @(negedge clk);
    A = aa[0]; B = bb[0]; mode = 3'd3; strt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      chk("b2b_gap", 32'(n), 32'(2));
      chk("b2b_y", 32'(Y), 32'(ref_y(aa[i], bb[i], 3'd3)));
      chk("b2b_ovfl", 32'(ovfl), 32'(FLAGS & ref_ovf(aa[i], bb[i], 3'd3)));
      chk("b2b_zero", 32'(zero), 32'(FLAGS & (ref_y(aa[i], bb[i], 3'd3) == 8'h00)));
      if (i < 3) begin
        A = aa[i + 1]; B = bb[i + 1];
      end else begin
        strt = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end_busy", 32'(busy), 32'(0));
    chk("b2b_end_done", 32'(done), 32'(0));

    // Reset in the middle of a 7-step rotate.
    run_op(8'h12, 8'h34, 3'd3, "pre_rst");
    @(negedge clk);
    A = 8'hA5; B = 8'h07; mode = 3'd5; strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(Y), 32'(0));
    chk("arst_outs", 32'({done, busy, ovfl, zero}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("arst_no_done", 32'(pulses), 32'(0));
    run_op(8'h05, 8'h07, 3'd0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
